// File: rtl/iir_stream_pkg.sv
// Shared types, constants and the requantizer for the IIR sample streamer.
package iir_stream_pkg;

  typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 16;
  localparam int RQ_W = 64;

  typedef struct packed {
    logic                   sat;
    logic signed [RQ_W-1:0] val;
  } rq_t;

  // Round half up at the first dropped bit, shift, then clamp to out_w signed bits.
  function automatic rq_t requantize(input logic signed [RQ_W-1:0] x,
                                     input int shift,
                                     input int out_w);
    rq_t r;
    logic signed [RQ_W-1:0] one, rounded, max_code, min_code;
    one      = {{(RQ_W-1){1'b0}}, 1'b1};
    rounded  = (x + (one <<< (shift - 1))) >>> shift;
    max_code = (one <<< (out_w - 1)) - one;
    min_code = -(one <<< (out_w - 1));
    r.sat = 1'b0;
    r.val = rounded;
    if (rounded > max_code) begin
      r.sat = 1'b1;
      r.val = max_code;
    end else if (rounded < min_code) begin
      r.sat = 1'b1;
      r.val = min_code;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with separate occupancy count and synchronous clear.
module sample_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/iir_sample_streamer.sv
// Rate-controlled feeder and result requantizer wrapped around an SOS filter stage.
module iir_sample_streamer
  import iir_stream_pkg::*;
#(
  parameter int WI_IN  = 8,
  parameter int WF_IN  = 18,
  parameter int WI_OUT = 13,
  parameter int WF_OUT = 29,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WI_IN+WF_IN-1:0]    in_sample,
  input  logic [DIV_W-1:0]          rate_div,
  output logic [WI_IN+WF_IN-1:0]    filt_sample,
  output logic                      filt_CE,
  output logic                      filt_nReset,
  input  logic [WI_OUT+WF_OUT-1:0]  Filt_Out,
  input  logic                      overFlow,
  output logic                      out_valid,
  output logic [WI_OUT+WF_OUT-1:0]  out_full,
  output logic [WI_IN+WF_IN-1:0]    out_sample,
  output logic                      out_sat,
  output logic                      sticky_ovf,
  output logic [CNT_W-1:0]          sat_count,
  output logic [CNT_W-1:0]          underrun_count
);

  localparam int SW    = WI_IN + WF_IN;
  localparam int OW    = WI_OUT + WF_OUT;
  localparam int SHIFT = WF_OUT - WF_IN;

  state_t           state, state_nxt;
  logic [1:0]       flush_cnt, flush_cnt_nxt;
  logic             active, clr, tick, strobe, underrun, fifo_push;
  logic             fifo_full, fifo_empty;
  logic [SW-1:0]    fifo_head, held_sample;
  logic [DIV_W-1:0] rate_cnt;
  logic [CNT_W-1:0] sat_cnt, ur_cnt;
  logic             sticky;

  logic                 vld_p1, vld_p2, sat_p2;
  logic signed [OW-1:0] cap_p1, full_p2;
  logic signed [SW-1:0] sample_p2;
  rq_t                  rq;
  logic                 unused_rq_hi;

  always_ff @(posedge CLK) begin
    if (Reset || flush) begin
      state     <= FLUSH;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      FLUSH: begin
        if (flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
          state_nxt     = RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + 2'd1;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Reset/flush gate the strobe in the same cycle so nothing escapes while the FSM drops to FLUSH.
  always_comb begin
    active      = (state == RUN) && !Reset && !flush;
    clr         = !active;
    tick        = active && (rate_cnt == '0);
    strobe      = tick && !fifo_empty;
    underrun    = tick && fifo_empty;
    in_ready    = active && !fifo_full;
    fifo_push   = in_valid && in_ready;
    filt_nReset = active;
    filt_CE     = strobe;
    filt_sample = strobe ? fifo_head : held_sample;
  end

  sample_fifo #(
    .DATA_W (SW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .clear   (clr),
    .push    (fifo_push),
    .pop     (strobe),
    .wr_data (in_sample),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (clr || tick) rate_cnt <= rate_div;
    else             rate_cnt <= rate_cnt - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      held_sample <= '0;
      sticky      <= 1'b0;
      ur_cnt      <= '0;
    end else begin
      if (strobe)               held_sample <= fifo_head;
      if (strobe && overFlow)   sticky      <= 1'b1;
      if (underrun && ur_cnt != '1) ur_cnt  <= ur_cnt + 1'b1;
    end
  end

  // Stage 1: capture the filter result on the strobed cycle.
  always_ff @(posedge CLK) begin
    if (clr) vld_p1 <= 1'b0;
    else     vld_p1 <= strobe;
  end

  always_ff @(posedge CLK) begin
    if (strobe) cap_p1 <= Filt_Out;
  end

  // Stage 2: requantize to the sample format and count saturations.
  assign rq = requantize({{(RQ_W-OW){cap_p1[OW-1]}}, cap_p1}, SHIFT, SW);
  // After clamping the bits above the sample width are only sign copies.
  assign unused_rq_hi = ^rq.val[RQ_W-1:SW];

  always_ff @(posedge CLK) begin
    if (clr) begin
      vld_p2    <= 1'b0;
      sat_p2    <= 1'b0;
      full_p2   <= '0;
      sample_p2 <= '0;
      sat_cnt   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sat_p2 <= vld_p1 && rq.sat;
      if (vld_p1) begin
        full_p2   <= cap_p1;
        sample_p2 <= rq.val[SW-1:0];
      end
      if (vld_p1 && rq.sat && sat_cnt != '1) sat_cnt <= sat_cnt + 1'b1;
    end
  end

  assign out_valid      = vld_p2;
  assign out_sat        = sat_p2;
  assign out_full       = full_p2;
  assign out_sample     = sample_p2;
  assign sticky_ovf     = sticky;
  assign sat_count      = sat_cnt;
  assign underrun_count = ur_cnt;

endmodule

// File: tb/tb_iir_sample_streamer.sv
// Directed bench for iir_sample_streamer: reset, rate, requantization, FIFO flow and flush.
module tb_iir_sample_streamer;

  localparam int SW = 26;
  localparam int OW = 42;

  logic          CLK = 1'b0;
  logic          Reset, flush, in_valid, overFlow;
  logic [SW-1:0] in_sample;
  logic [7:0]    rate_div;
  logic [OW-1:0] Filt_Out;
  logic          in_ready, filt_CE, filt_nReset, out_valid, out_sat, sticky_ovf;
  logic [SW-1:0] filt_sample, out_sample;
  logic [OW-1:0] out_full;
  logic [15:0]   sat_count, underrun_count;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] fo_vec [8];
  int            n_vec;
  logic [SW-1:0] obs_sample [8];
  logic          obs_sat [8];
  logic [OW-1:0] obs_full [8];
  int            obs_cyc [8];
  int            n_obs;

  always #5 CLK = ~CLK;

  iir_sample_streamer dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .rate_div       (rate_div),
    .filt_sample    (filt_sample),
    .filt_CE        (filt_CE),
    .filt_nReset    (filt_nReset),
    .Filt_Out       (Filt_Out),
    .overFlow       (overFlow),
    .out_valid      (out_valid),
    .out_full       (out_full),
    .out_sample     (out_sample),
    .out_sat        (out_sat),
    .sticky_ovf     (sticky_ovf),
    .sat_count      (sat_count),
    .underrun_count (underrun_count)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in the first RUN cycle.
  task automatic do_reset(input logic [7:0] div);
    rate_div = div; Reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_sample = '0; overFlow = 1'b0; Filt_Out = '0;
    repeat (3) step();
    Reset = 1'b0;
    step();
    step();
  endtask

  // rate_div = 0: push n_vec samples, answer each strobe with the next Filt_Out vector.
  task automatic run_vectors();
    int k, pushed;
    k = 0; pushed = 0; n_obs = 0;
    for (int cyc = 0; cyc < n_vec + 12; cyc++) begin
      if (out_valid && n_obs < 8) begin
        obs_sample[n_obs] = out_sample; obs_sat[n_obs] = out_sat;
        obs_full[n_obs] = out_full; obs_cyc[n_obs] = cyc; n_obs++;
      end
      if (filt_CE) begin
        if (k < n_vec) Filt_Out = fo_vec[k];
        k++;
      end
      in_valid = (pushed < n_vec);
      in_sample = SW'(pushed + 1);
      if (in_valid && in_ready) pushed++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sample = '0;
    rate_div = 8'd0; overFlow = 1'b0; Filt_Out = '0;
    repeat (3) step();
    checks++;
    if ({filt_nReset, in_ready, filt_CE, out_valid, out_sat, sticky_ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {filt_nReset, in_ready, filt_CE, out_valid, out_sat, sticky_ovf});
    end
    checks++;
    if ({sat_count, underrun_count, out_sample, out_full, filt_sample} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h/%h want 0",
                         sat_count, underrun_count, out_sample, out_full, filt_sample);
    end
    Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (filt_nReset !== (c == 3) || in_ready !== (c == 3)) begin
        errors++; $display("FAIL reset_release_c%0d got nReset=%b ready=%b want %b",
                           c, filt_nReset, in_ready, (c == 3));
      end
      if (c < 3) step();
    end
  endtask

  task automatic test_rate();
    int ce_cyc [4]; logic [SW-1:0] ce_val [4]; int ov_cyc [4];
    int nce, nov;
    nce = 0; nov = 0;
    do_reset(8'd3);
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (filt_CE) begin
        if (nce < 4) begin ce_cyc[nce] = cyc; ce_val[nce] = filt_sample; end
        nce++;
      end
      if (out_valid) begin
        if (nov < 4) ov_cyc[nov] = cyc;
        nov++;
      end
      in_valid = (cyc < 2);
      in_sample = (cyc == 0) ? 26'h0040000 : 26'h0080000;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (nce !== 2 || nov !== 2) begin
      errors++; $display("FAIL rate_counts got ce=%0d ov=%0d want 2/2", nce, nov);
    end else begin
      checks++;
      if (ce_cyc[0] !== 3 || ce_cyc[1] - ce_cyc[0] !== 4) begin
        errors++; $display("FAIL rate_spacing got %0d,%0d want 3,7", ce_cyc[0], ce_cyc[1]);
      end
      checks++;
      if (ce_val[0] !== 26'h0040000 || ce_val[1] !== 26'h0080000) begin
        errors++; $display("FAIL rate_values got %h,%h want 0040000,0080000", ce_val[0], ce_val[1]);
      end
      checks++;
      if (ov_cyc[0] !== ce_cyc[0] + 2 || ov_cyc[1] !== ce_cyc[1] + 2) begin
        errors++; $display("FAIL rate_latency got %0d,%0d want 5,9", ov_cyc[0], ov_cyc[1]);
      end
    end
    checks++;
    if (filt_sample !== 26'h0080000) begin
      errors++; $display("FAIL rate_hold got %h want 0080000", filt_sample);
    end
    checks++;
    if (underrun_count !== 16'd3) begin
      errors++; $display("FAIL rate_underrun got %0d want 3", underrun_count);
    end
  endtask

  task automatic test_requant();
    logic [SW-1:0] exp_s [3];
    exp_s = '{26'h0060000, 26'h0000001, 26'h0000000};
    do_reset(8'd0);
    fo_vec[0] = 42'h000_3000_0000;
    fo_vec[1] = 42'h000_0000_0400;
    fo_vec[2] = 42'h3FF_FFFF_FC00;
    n_vec = 3;
    run_vectors();
    checks++;
    if (n_obs !== 3) begin
      errors++; $display("FAIL requant_count got %0d want 3", n_obs);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_sample[i] !== exp_s[i] || obs_sat[i] !== 1'b0) begin
          errors++; $display("FAIL requant_%0d got %h sat=%b want %h sat=0",
                             i, obs_sample[i], obs_sat[i], exp_s[i]);
        end
        checks++;
        if (obs_full[i] !== fo_vec[i]) begin
          errors++; $display("FAIL requant_full_%0d got %h want %h", i, obs_full[i], fo_vec[i]);
        end
      end
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++; $display("FAIL requant_satcnt got %0d want 0", sat_count);
    end
  endtask

  task automatic test_saturate();
    do_reset(8'd0);
    fo_vec[0] = 42'h019_0000_0000;
    fo_vec[1] = 42'h3DA_8000_0000;
    n_vec = 2;
    run_vectors();
    checks++;
    if (n_obs !== 2) begin
      errors++; $display("FAIL sat_count_obs got %0d want 2", n_obs);
    end else begin
      checks++;
      if (obs_sample[0] !== 26'h1FFFFFF || obs_sat[0] !== 1'b1) begin
        errors++; $display("FAIL sat_pos got %h sat=%b want 1ffffff sat=1", obs_sample[0], obs_sat[0]);
      end
      checks++;
      if (obs_sample[1] !== 26'h2000000 || obs_sat[1] !== 1'b1) begin
        errors++; $display("FAIL sat_neg got %h sat=%b want 2000000 sat=1", obs_sample[1], obs_sat[1]);
      end
    end
    checks++;
    if (sat_count !== 16'd2) begin
      errors++; $display("FAIL sat_counter got %0d want 2", sat_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] exp_s [4];
    logic          exp_t [4];
    exp_s = '{26'h1FFFFFF, 26'h1FFFFFF, 26'h2000000, 26'h2000000};
    exp_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(8'd0);
    fo_vec[0] = 42'h00F_FFFF_FBFF;
    fo_vec[1] = 42'h00F_FFFF_FC00;
    fo_vec[2] = 42'h3EF_FFFF_FC00;
    fo_vec[3] = 42'h3EF_FFFF_FBFF;
    n_vec = 4;
    run_vectors();
    checks++;
    if (n_obs !== 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", n_obs);
    end else begin
      checks++;
      if (obs_cyc[0] !== 3 || obs_cyc[3] !== 6) begin
        errors++; $display("FAIL b2b_timing got %0d..%0d want 3..6", obs_cyc[0], obs_cyc[3]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_sample[i] !== exp_s[i] || obs_sat[i] !== exp_t[i]) begin
          errors++; $display("FAIL b2b_edge_%0d got %h sat=%b want %h sat=%b",
                             i, obs_sample[i], obs_sat[i], exp_s[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (sat_count !== 16'd2) begin
      errors++; $display("FAIL b2b_satcnt got %0d want 2", sat_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [SW-1:0] got [16];
    int ng, drop_cyc, rise_cyc, next_val, ur_mid;
    ng = 0; drop_cyc = -1; rise_cyc = -1; next_val = 1; ur_mid = -1;
    do_reset(8'd15);
    for (int cyc = 0; cyc < 208; cyc++) begin
      if (filt_CE) begin
        if (ng < 16) got[ng] = filt_sample;
        ng++;
      end
      if (drop_cyc < 0 && !in_ready) drop_cyc = cyc;
      else if (drop_cyc >= 0 && rise_cyc < 0 && in_ready) rise_cyc = cyc;
      if (cyc == 160) ur_mid = int'(underrun_count);
      in_valid = (next_val <= 10);
      in_sample = SW'(next_val);
      if (in_valid && in_ready) next_val++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (drop_cyc !== 8 || rise_cyc !== 16) begin
      errors++; $display("FAIL fifo_ready got drop=%0d rise=%0d want 8/16", drop_cyc, rise_cyc);
    end
    checks++;
    if (ng !== 10) begin
      errors++; $display("FAIL fifo_issued got %0d want 10", ng);
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] !== SW'(i + 1)) begin
          errors++; $display("FAIL fifo_order_%0d got %h want %h", i, got[i], SW'(i + 1));
        end
      end
    end
    checks++;
    if (ur_mid !== 0 || underrun_count !== 16'd3) begin
      errors++; $display("FAIL fifo_underrun got %0d then %0d want 0 then 3", ur_mid, underrun_count);
    end
  endtask

  task automatic test_flush();
    int n_ce, stale, ce_after;
    n_ce = 0; stale = 0; ce_after = 0;
    do_reset(8'd3);
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc < 13 && filt_CE) n_ce++;
      if (cyc >= 13 && out_valid) stale++;
      if (cyc >= 13 && filt_CE) ce_after++;
      if (cyc == 12) begin
        checks++;
        if (sticky_ovf !== 1'b1 || sat_count !== 16'd1 || underrun_count !== 16'd1 || n_ce !== 2) begin
          errors++; $display("FAIL flush_pre got sticky=%b sat=%0d ur=%0d ce=%0d want 1/1/1/2",
                             sticky_ovf, sat_count, underrun_count, n_ce);
        end
      end
      if (cyc == 13) begin
        checks++;
        if (sticky_ovf !== 1'b0 || sat_count !== 16'd0 || underrun_count !== 16'd0 ||
            in_ready !== 1'b0 || filt_nReset !== 1'b0 || filt_sample !== '0) begin
          errors++; $display("FAIL flush_post got sticky=%b sat=%0d ur=%0d rdy=%b nrst=%b fs=%h want 0",
                             sticky_ovf, sat_count, underrun_count, in_ready, filt_nReset, filt_sample);
        end
      end
      in_valid  = (cyc == 4 || cyc == 5 || cyc == 8 || cyc == 9);
      in_sample = SW'(cyc + 1);
      overFlow  = (cyc == 7);
      Filt_Out  = (cyc == 7) ? 42'h019_0000_0000 : 42'h000_2000_0000;
      flush     = (cyc == 12);
      step();
    end
    in_valid = 1'b0; overFlow = 1'b0;
    checks++;
    if (stale !== 0 || ce_after !== 0) begin
      errors++; $display("FAIL flush_stale got ov=%0d ce=%0d want 0/0", stale, ce_after);
    end
    checks++;
    if (underrun_count !== 16'd1) begin
      errors++; $display("FAIL flush_empty got %0d want 1", underrun_count);
    end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_requant();
    test_saturate();
    test_back_to_back();
    test_fifo_full();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_sample_streamer.md
# iir_sample_streamer

Rate-controlled source and sink for the fixed-point SOS filter stage. It accepts input samples on a valid/ready stream, buffers them in a small FIFO, and issues them to the filter at a programmable sample rate with a one-cycle `filt_CE` strobe. It captures the filter result for each strobe, requantizes it back to the input sample format with rounding and saturation, and keeps overflow, saturation and underrun statistics.

## Interface
- `WI_IN`, 8, integer bits of the input and requantized output sample
- `WF_IN`, 18, fraction bits of the input and requantized output sample
- `WI_OUT`, 13, integer bits of the filter result; must satisfy `WI_OUT >= WI_IN`
- `WF_OUT`, 29, fraction bits of the filter result; must satisfy `WF_OUT > WF_IN`
- `DEPTH`, 8, FIFO entries; must be a power of 2 and at least 2
- `DIV_W`, 8, width of `rate_div`
- `CLK`  in  1  single clock; all logic on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous flush; same effect as `Reset` on state and statistics
- `in_valid`  in  1  upstream sample valid
- `in_ready`  out  1  FIFO can accept a sample; equals `!full` while in RUN, otherwise 0
- `in_sample`  in  WI_IN+WF_IN  signed Q(WI_IN.WF_IN) sample
- `rate_div`  in  DIV_W  issue period minus 1, in clock cycles
- `filt_sample`  out  WI_IN+WF_IN  sample presented to the filter
- `filt_CE`  out  1  one-cycle strobe; the filter advances its state only on strobed cycles
- `filt_nReset`  out  1  active-low reset to the filter
- `Filt_Out`  in  WI_OUT+WF_OUT  filter result; combinational from `filt_sample` and the filter's state
- `overFlow`  in  1  filter overflow flag, same cycle as `Filt_Out`
- `out_valid`  out  1  one-cycle pulse; both output samples are valid
- `out_full`  out  WI_OUT+WF_OUT  captured full-precision result
- `out_sample`  out  WI_IN+WF_IN  requantized result
- `out_sat`  out  1  requantization saturated, qualified by `out_valid`
- `sticky_ovf`  out  1  sticky overflow flag
- `sat_count`  out  16  count of saturated outputs; saturates at 16'hFFFF
- `underrun_count`  out  16  count of ticks that found the FIFO empty; saturates at 16'hFFFF

## Operation
- **FSM states.** There are two states, FLUSH and RUN.
  - `Reset` or `flush` forces FLUSH from any state and restarts its 2-cycle timer.
  - After 2 FLUSH cycles with `Reset` and `flush` low, the FSM moves to RUN.
- **In FLUSH:**
  - `filt_nReset` = 0, `in_ready` = 0, `filt_CE` = 0.
  - The FIFO is emptied, pipeline valids are cleared, and `sticky_ovf` and both counters are cleared.
- **Rate counter.**
  - Loaded with `rate_div` on entry to RUN and on each tick.
  - Decrements every RUN cycle; a tick occurs when it equals 0.
  - `rate_div` = 0 gives a tick on every cycle.
  - A change to `rate_div` takes effect at the next reload.
- **On a tick:**
  - If the FIFO is non-empty: pop it, drive `filt_sample` = head, and set `filt_CE` = 1 for that cycle.
  - If the FIFO is empty: no strobe, and `underrun_count` increments.
  - `filt_sample` holds its last value between strobes.
- **FIFO.**
  - A push happens when `in_valid && in_ready`.
  - Read and write pointers wrap modulo `DEPTH`; a separate occupancy count runs 0..`DEPTH`.
  - When full, `in_ready` = 0, so there is no push even if a pop happens in the same cycle.
  - When empty, a push and a tick in the same cycle do not bypass: the tick counts as an underrun and the sample is issued at the next tick.
- **Capture.** On a strobed cycle, `Filt_Out` and `overFlow` are registered into stage 1. `sticky_ovf` is set if `overFlow` = 1 on any strobed cycle.
- **Requantize (stage 2).**
  - Add 1 at bit `WF_OUT-WF_IN-1` (round half up, toward +inf) in a width one bit wider than the input.
  - Drop the low `WF_OUT-WF_IN` bits.
  - If the result lies outside the signed `WI_IN+WF_IN` range, clamp to the max/min code and set `out_sat`; `sat_count` increments.

## Timing
- A strobe in cycle t gives `out_valid` in cycle t+2. `out_full` is the stage-1 value delayed one more register.
- The pipeline accepts one result per cycle (`rate_div` = 0).
- Reset values of all outputs are 0. This includes `filt_nReset` (filter held in reset) and `in_ready`.
- `Reset` or `flush` mid-operation discards any in-flight stage-1 and stage-2 results: no `out_valid` pulse follows.
- The earliest first push is 2 cycles after `Reset` and `flush` deassert. The earliest first strobe is `rate_div`+1 cycles after entering RUN.

## Structure
- Package `iir_stream_pkg` holds:
  - the FSM state enum (FLUSH, RUN);
  - `FLUSH_CYCLES` = 2;
  - the 16-bit counter width;
  - the requantize rounding/saturation function.
- Sub-module `sample_fifo`: a parameterized synchronous FIFO with push/pop, full/empty and a synchronous clear.

## Test plan
- Reset held 3 cycles, then released → `filt_nReset` = 0 for 2 more cycles; `in_ready` rises in the 3rd cycle after release; all outputs are 0 until then.
- `rate_div` = 3, push samples 1.0 (26'h0040000) and 2.0 → `filt_CE` pulses exactly 4 cycles apart with those values; `out_valid` follows each strobe by 2 cycles.
- `Filt_Out` = 1.5, then 2^-19, then -2^-19 → `out_sample` = 26'h0060000, 26'h0000001, 26'h0000000; `out_sat` = 0.
- `Filt_Out` = 200.0, then -300.0 → `out_sample` = 26'h1FFFFFF, then 26'h2000000; `out_sat` = 1 both times; `sat_count` = 2.
- Fill the FIFO with 8 samples and hold `in_valid` → `in_ready` = 0 until the first pop; no sample is lost or duplicated. Stop input → `underrun_count` increments once per tick.
- `overFlow` = 1 on one strobe, then `flush` asserted mid-stream → `sticky_ovf` = 1 until the flush; after the flush, all counters = 0, the FIFO is empty, and no stale `out_valid` appears.
